// File: rtl/vec_mem_sequencer.sv
// Serialises 256-bit vector loads/stores from the SIMD processor into 16 lane
// accesses on a 16-bit single-port RAM with registered reads.
module vec_mem_sequencer #(
  parameter int LANES  = 16,
  parameter int LANE_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    vreq,
  input  logic                    src_sel,
  input  logic                    memwrite,
  input  logic [31:0]             dataadr,
  input  logic [LANES*LANE_W-1:0] w_data_b,
  output logic [LANES*LANE_W-1:0] q_b,
  output logic                    stall,
  output logic                    done,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic                    ram_we,
  output logic [LANE_W-1:0]       ram_wdata,
  input  logic [LANE_W-1:0]       ram_rdata
);

  localparam int CW = $clog2(LANES);

  typedef enum logic [2:0] {IDLE, STORE, LOAD, LWAIT, DONE} state_t;

  state_t                    state, next_state;
  logic [ADDR_W-1:0]         base;
  logic                      op;
  logic [LANES*LANE_W-1:0]   data;
  logic [CW-1:0]             cnt;
  logic [CW-1:0]             prev_cnt;
  logic                      accept;
  logic                      last_lane;
  logic                      unused_bits;

  assign accept      = (state == IDLE) && vreq && src_sel;
  assign last_lane   = (cnt == CW'(LANES - 1));
  assign prev_cnt    = cnt - 1'b1;
  assign unused_bits = ^dataadr[31:ADDR_W];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = memwrite ? STORE : LOAD;
      STORE:   if (last_lane) next_state = DONE;
      LOAD:    if (last_lane) next_state = LWAIT;
      LWAIT:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Read data trails the address by one cycle, so each LOAD cycle captures the
  // previous lane and LWAIT picks up the final one.
  always_ff @(posedge clk) begin
    if (reset) begin
      base <= '0;
      op   <= 1'b0;
      data <= '0;
      cnt  <= '0;
      q_b  <= '0;
    end else begin
      if (accept) begin
        base <= dataadr[ADDR_W-1:0];
        op   <= memwrite;
        data <= w_data_b;
        cnt  <= '0;
      end else if (state == STORE || state == LOAD) begin
        cnt <= cnt + 1'b1;
      end
      if (state == LOAD && cnt != '0)
        q_b[int'(prev_cnt)*LANE_W +: LANE_W] <= ram_rdata;
      if (state == LWAIT)
        q_b[(LANES-1)*LANE_W +: LANE_W] <= ram_rdata;
    end
  end

  always_comb begin
    stall     = accept || state == STORE || state == LOAD || state == LWAIT;
    done      = (state == DONE);
    ram_we    = (state == STORE);
    ram_addr  = '0;
    ram_wdata = '0;
    if (state == STORE || state == LOAD)
      ram_addr = base + {{(ADDR_W-CW){1'b0}}, cnt};
    if (state == STORE)
      ram_wdata = data[int'(cnt)*LANE_W +: LANE_W];
  end

  // op is kept for visibility of the accepted operation; the state encodes it.
  logic unused_op;
  assign unused_op = op;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed self-checking bench for vec_mem_sequencer with a behavioural RAM
// model and a load-result scoreboard.
module tb_vec_mem_sequencer;

  logic         clk, reset, vreq, src_sel, memwrite;
  logic [31:0]  dataadr;
  logic [255:0] w_data_b, q_b;
  logic         stall, done, ram_we;
  logic [15:0]  ram_addr, ram_wdata, ram_rdata;

  logic [15:0]  mem [0:65535];
  logic [255:0] exp_q [$];
  int assert_count = 0;
  int fail_count   = 0;
  int done_count   = 0;
  int we_count     = 0;

  vec_mem_sequencer #(.LANES(16), .LANE_W(16), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .vreq(vreq), .src_sel(src_sel),
    .memwrite(memwrite), .dataadr(dataadr), .w_data_b(w_data_b),
    .q_b(q_b), .stall(stall), .done(done), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (done)   done_count++;
    if (ram_we) we_count++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [255:0] obs,
                              input logic [255:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives a request in cycle T; loads also push their expected result.
  task automatic apply_stimulus(input logic wr, input logic [31:0] adr,
                                input logic [255:0] wd, input logic [255:0] exp_load);
    vreq = 1'b1; src_sel = 1'b1; memwrite = wr; dataadr = adr; w_data_b = wd;
    if (!wr) exp_q.push_back(exp_load);
    #1;
    check_output("accept_stall", 256'(stall), 256'(1'b1));
  endtask

  // Counts cycles after acceptance until done, scrambling inputs to prove latching.
  task automatic wait_done(input string tag, input int exp_lat, input logic is_load);
    int k;
    int stall_hi;
    logic [255:0] got;
    stall_hi = 0;
    for (k = 1; k <= 40; k++) begin
      tick();
      if (k == 1) begin
        dataadr  = dataadr ^ 32'h0000_5555;
        w_data_b = ~w_data_b;
        memwrite = ~memwrite;
      end
      if (done) break;
      if (stall) stall_hi++;
    end
    check_output({tag, "_latency"}, 256'(k), 256'(exp_lat));
    check_output({tag, "_stall_cycles"}, 256'(stall_hi), 256'(exp_lat - 1));
    check_output({tag, "_stall_in_done"}, 256'(stall), 256'(1'b0));
    if (is_load) begin
      if (exp_q.size() > 0) begin
        got = exp_q.pop_front();
        check_output({tag, "_q_b"}, q_b, got);
      end else begin
        check_output({tag, "_scoreboard_empty"}, 256'(1'b1), 256'(1'b0));
      end
    end
  endtask

  initial begin
    logic [255:0] d;
    int we0, dc0, viol;

    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 16; i++) mem[16'h0040 + i] = 16'hA5A0 + 16'(i);
    reset = 1'b1; vreq = 1'b0; src_sel = 1'b0; memwrite = 1'b0;
    dataadr = '0; w_data_b = '0;
    repeat (3) tick();
    check_output("rst_q_b", q_b, '0);
    check_output("rst_stall", 256'(stall), '0);
    check_output("rst_done", 256'(done), '0);
    check_output("rst_ram_we", 256'(ram_we), '0);
    check_output("rst_ram_addr", 256'(ram_addr), '0);
    check_output("rst_ram_wdata", 256'(ram_wdata), '0);
    reset = 1'b0;
    tick();

    // Store at 0x0010 (upper address bits must be ignored)
    for (int i = 0; i < 16; i++) d[16*i +: 16] = 16'h1000 + 16'(i);
    we0 = we_count;
    apply_stimulus(1'b1, 32'h0001_0010, d, '0);
    wait_done("store", 17, 1'b0);
    vreq = 1'b0;
    check_output("store_we_cycles", 256'(we_count - we0), 256'(16));
    for (int i = 0; i < 16; i++)
      check_output($sformatf("store_mem_%0d", i), 256'(mem[16'h0010 + i]), 256'(16'h1000 + 16'(i)));
    check_output("q_b_before_load", q_b, '0);

    // Load from preloaded 0x0040
    tick();
    for (int i = 0; i < 16; i++) d[16*i +: 16] = 16'hA5A0 + 16'(i);
    we0 = we_count;
    apply_stimulus(1'b0, 32'h0000_0040, '0, d);
    wait_done("load", 18, 1'b1);
    vreq = 1'b0;
    check_output("load_no_we", 256'(we_count - we0), '0);

    // Address wrap at 0xFFFE
    tick();
    for (int i = 0; i < 16; i++) d[16*i +: 16] = 16'(i);
    apply_stimulus(1'b1, 32'h0000_FFFE, d, '0);
    wait_done("wrap_store", 17, 1'b0);
    vreq = 1'b0;
    tick();
    check_output("wrap_mem_fffe", 256'(mem[16'hFFFE]), 256'(0));
    check_output("wrap_mem_ffff", 256'(mem[16'hFFFF]), 256'(1));
    check_output("wrap_mem_0000", 256'(mem[16'h0000]), 256'(2));
    check_output("wrap_mem_000d", 256'(mem[16'h000D]), 256'(15));
    apply_stimulus(1'b0, 32'h0000_FFFE, '0, d);
    wait_done("wrap_load", 18, 1'b1);
    vreq = 1'b0;

    // Back-to-back with vreq held: second acceptance only in IDLE after DONE
    tick();
    dc0 = done_count;
    for (int i = 0; i < 16; i++) d[16*i +: 16] = 16'h5A00 + 16'(3 * i);
    apply_stimulus(1'b1, 32'h0000_0100, d, '0);
    wait_done("b2b_store", 17, 1'b0);
    memwrite = 1'b0; dataadr = 32'h0000_0100; w_data_b = '0;
    exp_q.push_back(d);
    tick();
    check_output("b2b_idle_accept_stall", 256'(stall), 256'(1'b1));
    check_output("b2b_idle_done", 256'(done), '0);
    wait_done("b2b_load", 18, 1'b1);
    vreq = 1'b0;
    repeat (3) tick();
    check_output("b2b_done_pulses", 256'(done_count - dc0), 256'(2));

    // Reset in cycle T+5 of a store
    for (int i = 0; i < 16; i++) d[16*i +: 16] = 16'hBEE0 + 16'(i);
    apply_stimulus(1'b1, 32'h0000_0200, d, '0);
    repeat (5) tick();
    reset = 1'b1; vreq = 1'b0;
    tick();
    check_output("mid_rst_stall", 256'(stall), '0);
    check_output("mid_rst_we", 256'(ram_we), '0);
    check_output("mid_rst_done", 256'(done), '0);
    check_output("mid_rst_q_b", q_b, '0);
    reset = 1'b0;
    we0 = we_count; dc0 = done_count;
    repeat (20) tick();
    check_output("mid_rst_no_writes", 256'(we_count - we0), '0);
    check_output("mid_rst_no_done", 256'(done_count - dc0), '0);
    for (int i = 0; i < 5; i++)
      check_output($sformatf("mid_rst_mem_%0d", i), 256'(mem[16'h0200 + i]), 256'(16'hBEE0 + 16'(i)));
    check_output("mid_rst_mem_5", 256'(mem[16'h0205]), '0);

    // Scalar requests are ignored
    vreq = 1'b1; src_sel = 1'b0; memwrite = 1'b1; dataadr = 32'h0000_0300;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (stall || ram_we || done) viol++;
    end
    check_output("scalar_ignored", 256'(viol), '0);
    vreq = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
